// File: rtl/pe_pkg.sv
// Shared constants and helpers for the MSB-first priority encoder.
package pe_pkg;

  localparam int unsigned PE_WIDTH_DEFAULT = 8;

  // Index width for a w-input encoder; never below one bit.
  function automatic int unsigned pe_ow(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/pe_comb.sv
// Combinational MSB-first priority scan; forced idle when disabled.
module pe_comb
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = PE_WIDTH_DEFAULT,
  parameter int unsigned OW    = pe_ow(WIDTH)
) (
  input  logic             EN,
  input  logic [WIDTH-1:0] I,
  output logic [OW-1:0]    idx_c,
  output logic             any_c
);

  // Ascending scan: the last set bit seen is the most significant one.
  // I is never examined while disabled, so unknown request bits cannot leak out.
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    if (EN) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (I[i]) begin
          idx_c = OW'(i);
          any_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pe_design.sv
// Registered priority encoder: one-cycle latency from EN/I to Y/V.
module pe_design
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = PE_WIDTH_DEFAULT,
  parameter int unsigned OW    = pe_ow(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [WIDTH-1:0] I,
  output logic [OW-1:0]    Y,
  output logic             V
);

  logic [OW-1:0] idx_c;
  logic          any_c;

  pe_comb #(
    .WIDTH (WIDTH),
    .OW    (OW)
  ) u_comb (
    .EN    (EN),
    .I     (I),
    .idx_c (idx_c),
    .any_c (any_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y <= '0;
      V <= 1'b0;
    end else begin
      Y <= idx_c;
      V <= any_c;
    end
  end

endmodule

// File: tb/tb_pe_design.sv
// Self-checking bench for pe_design at WIDTH=8 and WIDTH=5.
module tb_pe_design;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en8, en5;
  logic [7:0] i8;
  logic [4:0] i5;
  logic [2:0] y8, y5;
  logic       v8, v5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_design #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .EN(en8), .I(i8), .Y(y8), .V(v8)
  );

  pe_design #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .EN(en5), .I(i5), .Y(y5), .V(v5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: floor(log2(val)) by repeated halving; idle when disabled or empty.
  function automatic logic [7:0] ref_y(input bit en, input logic [63:0] val);
    logic [63:0] v;
    int n;
    if (!en || val == 64'd0) return 8'd0;
    v = val;
    n = 0;
    while (v > 64'd1) begin
      v = v >> 1;
      n++;
    end
    return 8'(n);
  endfunction

  function automatic bit ref_v(input bit en, input logic [63:0] val);
    return en && (val != 64'd0);
  endfunction

  // Apply inputs, compute expectations, then check one edge later.
  task automatic step(input string tag, input bit e8, input logic [7:0] d8,
                      input bit e5, input logic [4:0] d5);
    logic [7:0] ey8, ey5;
    bit         ev8, ev5;
    en8 = e8; i8 = d8; en5 = e5; i5 = d5;
    ey8 = e8 ? ref_y(1'b1, 64'(d8)) : 8'd0;
    ev8 = e8 ? ref_v(1'b1, 64'(d8)) : 1'b0;
    ey5 = e5 ? ref_y(1'b1, 64'(d5)) : 8'd0;
    ev5 = e5 ? ref_v(1'b1, 64'(d5)) : 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_y8"}, 64'(y8), 64'(ey8));
    check({tag, "_v8"}, 64'(v8), 64'(ev8));
    check({tag, "_y5"}, 64'(y5), 64'(ey5));
    check({tag, "_v5"}, 64'(v5), 64'(ev5));
  endtask

  initial begin
    logic [7:0] hot;
    logic [7:0] r8;
    logic [4:0] r5;

    rst_n = 1'b0;
    en8 = 1'b1; i8 = 8'h80;
    en5 = 1'b1; i5 = 5'h10;
    #2;
    check("rst_async_y8", 64'(y8), 64'd0);
    check("rst_async_v8", 64'(v8), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_y8", 64'(y8), 64'd0);
    check("rst_hold_v8", 64'(v8), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_y8", 64'(y8), 64'd7);
    check("rst_rel_v8", 64'(v8), 64'd1);
    check("rst_rel_y5", 64'(y5), 64'd4);

    // One-hot sweep from the top bit down
    hot = 8'h80;
    for (int k = 0; k < 8; k++) begin
      step($sformatf("onehot%0d", 7 - k), 1'b1, hot, 1'b1, hot[4:0]);
      check($sformatf("onehot_lit%0d", 7 - k), 64'(y8), 64'(7 - k));
      hot = hot >> 1;
    end

    step("prio_ff", 1'b1, 8'hFF, 1'b1, 5'h1F);
    check("prio_ff_lit", 64'(y8), 64'd7);
    step("prio_0c", 1'b1, 8'h0C, 1'b1, 5'h0C);
    check("prio_0c_lit", 64'(y8), 64'd3);
    step("prio_03", 1'b1, 8'h03, 1'b1, 5'h03);
    check("prio_03_lit", 64'(y8), 64'd1);
    step("prio_61", 1'b1, 8'h61, 1'b1, 5'h11);
    check("prio_61_lit", 64'(y8), 64'd6);

    step("zero", 1'b1, 8'h00, 1'b1, 5'h00);
    step("dis_x", 1'b0, 8'hxx, 1'b0, 5'hxx);
    check("dis_x_known", 64'($isunknown({y8, v8, y5, v5})), 64'd0);
    step("dis_ff", 1'b0, 8'hFF, 1'b0, 5'h1F);

    // Reset asserted mid-stream discards the pending result
    step("pre_rst", 1'b1, 8'h40, 1'b1, 5'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_y8", 64'(y8), 64'd0);
    check("mid_rst_v8", 64'(v8), 64'd0);
    check("mid_rst_v5", 64'(v5), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 1'b1, 8'h21, 1'b1, 5'h06);

    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0: r8 = 8'h00;
        1: r8 = 8'(1) << $urandom_range(0, 7);
        default: r8 = 8'($urandom);
      endcase
      r5 = ($urandom_range(0, 4) == 0) ? 5'h00 : 5'($urandom);
      step("rand", $urandom_range(0, 4) != 0, r8, $urandom_range(0, 4) != 0, r5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_design.md
PE_DESIGN -- requirements
Module: pe_design

Interface
REQ-001 Parameter WIDTH, default 8, meaning number of request inputs; legal values 2 to 64.
REQ-002 Parameter OW, default $clog2(WIDTH), meaning output index width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 EN  input  1  encoder enable; high = encode, low = force idle output.
REQ-006 I  input  WIDTH  request vector; bit WIDTH-1 is highest priority.
REQ-007 Y  output  OW  registered index of highest-priority asserted bit of I.
REQ-008 V  output  1  registered valid; high when Y names a real request.

Function
REQ-009 Each rising clk edge, when EN=1 and I!=0, Y SHALL take the index of the most-significant set bit of I, and V SHALL be 1.
REQ-010 Lower-priority set bits SHALL be ignored; e.g. I=8'b0110_0001 yields Y=6.
REQ-011 When EN=1 and I=0, Y SHALL be 0 and V SHALL be 0 on the next edge.
REQ-012 When EN=0, Y SHALL be 0 and V SHALL be 0 on the next edge, regardless of I, including X/Z bits on I.
REQ-013 Latency SHALL be exactly one clk cycle from sampled EN/I to Y/V; no handshake; a new result every cycle.
REQ-014 Y and V SHALL come directly from flops; no combinational path from inputs to outputs.
REQ-015 Y=0 with V=1 SHALL mean request bit 0; Y=0 with V=0 SHALL mean no request or disabled.
REQ-016 The encode function SHALL be correct for any WIDTH, including non-power-of-two values; Y never exceeds WIDTH-1.

Reset
REQ-017 While rst_n=0, Y SHALL be 0 and V SHALL be 0, taking effect immediately without waiting for clk.
REQ-018 The first result after rst_n deasserts SHALL appear on the first rising edge at which rst_n=1, computed from EN/I sampled at that edge.
REQ-019 Reset asserted mid-stream SHALL discard any result; there is no other internal state.

Structure
REQ-020 A shared package pe_pkg SHALL hold the WIDTH default constant and a function computing OW.
REQ-021 The combinational MSB-first encode SHALL be a sub-module pe_comb (inputs EN, I; outputs index and any-valid); pe_design registers its outputs.
REQ-022 pe_comb SHALL use a loop or tree scan, not a hand-written case table, so that it scales with WIDTH.

Verification
REQ-023 Reset: rst_n=0 with EN=1, I=8'h80 -> Y=0, V=0 asynchronously; release -> next edge Y=7, V=1.
REQ-024 One-hot sweep with EN=1: I=8'h80, 40, 20, 10, 08, 04, 02, 01 on successive cycles -> Y=7,6,5,4,3,2,1,0, each one cycle later, V=1.
REQ-025 Priority: EN=1, I=8'hFF -> Y=7; I=8'h0C -> Y=3; I=8'h03 -> Y=1; all V=1.
REQ-026 Zero input: EN=1, I=8'h00 -> Y=0, V=0.
REQ-027 Disable: EN=0, I=8'hxx then I=8'hFF -> Y=0, V=0 with no X on the outputs.
REQ-028 Random: 1000 cycles of random EN/I at WIDTH=8 and WIDTH=5 checked against a reference model at one-cycle latency.
